mem_port_arbiter: RTL and testbench

Shares the core's single synchronous memory port between the instruction-fetch stage (IF) and the load/store unit (LS). Each cycle it grants at most one requester, drives the memory command, and tracks ownership of every in-flight access through a fixed-latency tag pipeline. Read data is routed back to the owner, and in-flight fetch responses are discarded on a pipeline redirect. It sits between `fetch_stage`/LSU and the memory macro.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_arb_tag_pipe.sv | 32 +++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the memory port arbiter and its tag pipeline
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   we;
        logic   kill;
    } arb_tag_t;

    localparam arb_tag_t TAG_NONE = '{owner: OWN_NONE, we: 1'b0, kill: 1'b0};

    // A redirect only ever kills fetch entries; load/store entries pass untouched.
    function automatic arb_tag_t with_flush(arb_tag_t tag, logic flush);
        arb_tag_t res;
        res = tag;
        if (flush && tag.owner == OWN_IF) begin
            res.kill = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory command signals of the port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                if_req_valid;
    logic                if_req_ready;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_flush;
    logic                if_rsp_valid;
    logic [DATA_W-1:0]   if_rsp_data;

    logic                ls_req_valid;
    logic                ls_req_ready;
    logic [ADDR_W-1:0]   ls_addr;
    logic                ls_we;
    logic [DATA_W/8-1:0] ls_wstrb;
    logic [DATA_W-1:0]   ls_wdata;
    logic                ls_rsp_valid;
    logic [DATA_W-1:0]   ls_rsp_data;

    logic                mem_en;
    logic                mem_we;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req_valid, if_addr, if_flush,
        input  ls_req_valid, ls_addr, ls_we, ls_wstrb, ls_wdata,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
    );

    // Requester and memory side
    modport master (
        output if_req_valid, if_addr, if_flush,
        output ls_req_valid, ls_addr, ls_we, ls_wstrb, ls_wdata,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_tag_pipe.sv
// rtl/mem_arb_tag_pipe.sv - fixed-latency ownership tags for in-flight memory accesses
module mem_arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  arb_tag_t in_tag,
    input  logic     flush,
    output arb_tag_t tail
);

    arb_tag_t stage [MEM_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                stage[i] <= TAG_NONE;
            end
        end else begin
            stage[0] <= in_tag;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                stage[i] <= with_flush(stage[i-1], flush);
            end
        end
    end

    // The tail is killed combinationally so a flush also swallows the response leaving this cycle.
    assign tail = with_flush(stage[MEM_LATENCY-1], flush);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store; optional MEM_ARB_STARVE_GUARD_EN
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 4 || STARVE_LIMIT < 1 ||
        ADDR_W < 1 || DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_param
        $error("mem_port_arbiter: illegal parameter combination");
    end

    logic     if_grant;
    logic     ls_grant;
    logic     force_if;
    arb_tag_t grant_tag;
    arb_tag_t tail;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    assign force_if = (starve_cnt == CNT_MAX) && bus.if_req_valid && !bus.if_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!bus.if_req_valid || if_grant) begin
            starve_cnt <= '0;
        end else if (ls_grant && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign ls_grant = bus.ls_req_valid && !force_if;
    assign if_grant = bus.if_req_valid && !bus.if_flush && (!bus.ls_req_valid || force_if);

    assign bus.ls_req_ready = ls_grant;
    assign bus.if_req_ready = if_grant;

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wstrb = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        grant_tag     = TAG_NONE;
        if (ls_grant) begin
            bus.mem_en      = 1'b1;
            bus.mem_we      = bus.ls_we;
            bus.mem_wstrb   = bus.ls_wstrb;
            bus.mem_addr    = bus.ls_addr;
            bus.mem_wdata   = bus.ls_wdata;
            grant_tag.owner = OWN_LS;
            grant_tag.we    = bus.ls_we;
        end else if (if_grant) begin
            bus.mem_en      = 1'b1;
            bus.mem_addr    = bus.if_addr;
            grant_tag.owner = OWN_IF;
        end
    end

    mem_arb_tag_pipe #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_tag (grant_tag),
        .flush  (bus.if_flush),
        .tail   (tail)
    );

    always_comb begin
        bus.if_rsp_valid = 1'b0;
        bus.if_rsp_data  = '0;
        bus.ls_rsp_valid = 1'b0;
        bus.ls_rsp_data  = '0;
        if (tail.owner == OWN_IF && !tail.kill) begin
            bus.if_rsp_valid = 1'b1;
            bus.if_rsp_data  = bus.mem_rdata;
        end
        if (tail.owner == OWN_LS) begin
            bus.ls_rsp_valid = 1'b1;
            bus.ls_rsp_data  = tail.we ? '0 : bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench driving latency-1 and latency-3 arbiters in lockstep
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int SL    = 4;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        if_v = 0, flush = 0, ls_v = 0, ls_we_s = 0;
    logic [31:0] if_a = 0, ls_a = 0, ls_wd = 0, if_exp = 0, ls_exp = 0;
    logic [3:0]  ls_strb = 0;

    int passed = 0;
    int total  = 0;
    int b_if_rsp_cnt = 0;

    exp_t qa_if[$], qa_ls[$], qb_if[$], qb_ls[$];

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT_A), .STARVE_LIMIT(SL))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT_B), .STARVE_LIMIT(SL))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    assign bus_a.if_req_valid = if_v;    assign bus_b.if_req_valid = if_v;
    assign bus_a.if_addr      = if_a;    assign bus_b.if_addr      = if_a;
    assign bus_a.if_flush     = flush;   assign bus_b.if_flush     = flush;
    assign bus_a.ls_req_valid = ls_v;    assign bus_b.ls_req_valid = ls_v;
    assign bus_a.ls_addr      = ls_a;    assign bus_b.ls_addr      = ls_a;
    assign bus_a.ls_we        = ls_we_s; assign bus_b.ls_we        = ls_we_s;
    assign bus_a.ls_wstrb     = ls_strb; assign bus_b.ls_wstrb     = ls_strb;
    assign bus_a.ls_wdata     = ls_wd;   assign bus_b.ls_wdata     = ls_wd;

    // Memory macros: word i initialised to 0xA5A5_0000 | i, reads return after the configured latency
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] rd_a [LAT_A];
    logic [31:0] rd_b [LAT_B];
    assign bus_a.mem_rdata = rd_a[LAT_A-1];
    assign bus_b.mem_rdata = rd_b[LAT_B-1];

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = 32'hA5A5_0000 | i;
        for (int i = 0; i < LAT_A; i++) rd_a[i] = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk);
            if (bus_a.mem_en && bus_a.mem_we)
                for (int b = 0; b < 4; b++)
                    if (bus_a.mem_wstrb[b]) mem_a[bus_a.mem_addr[9:2]][b*8 +: 8] <= bus_a.mem_wdata[b*8 +: 8];
            rd_a[0] <= (bus_a.mem_en && !bus_a.mem_we) ? mem_a[bus_a.mem_addr[9:2]] : 32'hBAD0_BAD0;
            for (int i = 1; i < LAT_A; i++) rd_a[i] <= rd_a[i-1];
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_b[i] = 32'hA5A5_0000 | i;
        for (int i = 0; i < LAT_B; i++) rd_b[i] = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk);
            if (bus_b.mem_en && bus_b.mem_we)
                for (int b = 0; b < 4; b++)
                    if (bus_b.mem_wstrb[b]) mem_b[bus_b.mem_addr[9:2]][b*8 +: 8] <= bus_b.mem_wdata[b*8 +: 8];
            rd_b[0] <= (bus_b.mem_en && !bus_b.mem_we) ? mem_b[bus_b.mem_addr[9:2]] : 32'hBAD0_BAD0;
            for (int i = 1; i < LAT_B; i++) rd_b[i] <= rd_b[i-1];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic mon(input string nm, input logic v, input logic [31:0] d, ref exp_t q[$]);
        exp_t e;
        if (v) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL %s unexpected response: got data %h expected none (cycle %0d)", nm, d, cyc);
            end else begin
                e = q.pop_front();
                chk({nm, "_data"}, d, e.data);
                chk({nm, "_cycle"}, cyc, e.due);
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            total++;
            $display("FAIL %s missing response: got none expected %h due cycle %0d", nm, e.data, e.due);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon("a_if", bus_a.if_rsp_valid, bus_a.if_rsp_data, qa_if);
            mon("a_ls", bus_a.ls_rsp_valid, bus_a.ls_rsp_data, qa_ls);
            mon("b_if", bus_b.if_rsp_valid, bus_b.if_rsp_data, qb_if);
            mon("b_ls", bus_b.ls_rsp_valid, bus_b.ls_rsp_data, qb_ls);
            if (bus_b.if_rsp_valid) b_if_rsp_cnt++;
        end
    end

    task automatic purge(ref exp_t q[$]);
        exp_t keep[$];
        foreach (q[i]) if (q[i].due < cyc) keep.push_back(q[i]);
        q = keep;
    endtask

    // One cycle: inputs already set; check grants and command, record expected responses.
    task automatic step(input logic exp_if, input logic exp_ls, input string nm);
        logic [31:0] e_addr;
        if (flush) begin
            purge(qa_if);
            purge(qb_if);
        end
        @(negedge clk);
        e_addr = exp_ls ? ls_a : (exp_if ? if_a : 32'h0);
        chk({nm, "_if_ready_a"}, bus_a.if_req_ready, exp_if);
        chk({nm, "_ls_ready_a"}, bus_a.ls_req_ready, exp_ls);
        chk({nm, "_if_ready_b"}, bus_b.if_req_ready, exp_if);
        chk({nm, "_ls_ready_b"}, bus_b.ls_req_ready, exp_ls);
        chk({nm, "_mem_en"},     bus_a.mem_en, exp_if | exp_ls);
        chk({nm, "_mem_addr"},   bus_a.mem_addr, e_addr);
        chk({nm, "_mem_we"},     bus_a.mem_we, exp_ls & ls_we_s);
        chk({nm, "_mem_wstrb"},  bus_a.mem_wstrb, exp_ls ? ls_strb : 4'h0);
        chk({nm, "_mem_wdata"},  bus_a.mem_wdata, exp_ls ? ls_wd : 32'h0);
        if (if_v && bus_a.if_req_ready) qa_if.push_back('{if_exp, cyc + LAT_A});
        if (if_v && bus_b.if_req_ready) qb_if.push_back('{if_exp, cyc + LAT_B});
        if (ls_v && bus_a.ls_req_ready) qa_ls.push_back('{ls_exp, cyc + LAT_A});
        if (ls_v && bus_b.ls_req_ready) qb_ls.push_back('{ls_exp, cyc + LAT_B});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, "idle");
    endtask

    initial begin
        int cnt0;
        logic g_if;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_ready", bus_a.if_req_ready, 0);
        chk("rst_mem_en", bus_b.mem_en, 0);
        chk("rst_if_rsp_valid", bus_b.if_rsp_valid, 0);
        chk("rst_ls_rsp_data", bus_a.ls_rsp_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        idle(10);

        // Fetch-only burst
        if_v = 1;
        if_a = 32'h8000_0000; if_exp = 32'hA5A5_0000; step(1, 0, "if0");
        if_a = 32'h8000_0004; if_exp = 32'hA5A5_0001; step(1, 0, "if1");
        if_a = 32'h8000_0008; if_exp = 32'hA5A5_0002; step(1, 0, "if2");
        if_v = 0;
        idle(4);

        // Contention: LS load wins, IF follows
        if_v = 1; if_a = 32'h8000_000C; if_exp = 32'hA5A5_0003;
        ls_v = 1; ls_a = 32'h0000_0100; ls_exp = 32'hA5A5_0040;
        step(0, 1, "both_ls");
        ls_v = 0;
        step(1, 0, "both_if");
        if_v = 0;
        idle(4);

        // Partial store, then read it back
        ls_v = 1; ls_we_s = 1; ls_strb = 4'b0011; ls_wd = 32'hDEAD_BEEF; ls_a = 32'h100; ls_exp = 32'h0;
        step(0, 1, "store");
        ls_we_s = 0; ls_strb = 4'h0; ls_wd = 32'h0; ls_exp = 32'hA5A5_BEEF;
        step(0, 1, "reload");
        ls_v = 0;
        idle(4);

        // Flush kills in-flight fetches; concurrent LS load survives
        cnt0 = b_if_rsp_cnt;
        if_v = 1;
        if_a = 32'h8000_0014; if_exp = 32'hA5A5_0005; step(1, 0, "fl_if0");
        if_a = 32'h8000_0018; if_exp = 32'hA5A5_0006; step(1, 0, "fl_if1");
        flush = 1; ls_v = 1; ls_a = 32'h104; ls_exp = 32'hA5A5_0041;
        step(0, 1, "fl_ls");
        ls_v = 0;
        step(0, 0, "fl_block");
        flush = 0; if_v = 0;
        idle(4);
        chk("flush_b_if_rsp_count", b_if_rsp_cnt - cnt0, 0);

        // Continuous contention: starvation behaviour
        if_v = 1; if_a = 32'h8000_0010; if_exp = 32'hA5A5_0004;
        ls_v = 1; ls_a = 32'h200; ls_exp = 32'hA5A5_0080;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            g_if = (i % 5) == 4;
`else
            g_if = 1'b0;
`endif
            step(g_if, !g_if, "starve");
        end
        if_v = 0; ls_v = 0;
        idle(4);

        // Reset mid-flight discards outstanding accesses
        ls_v = 1; ls_a = 32'h200; ls_exp = 32'hA5A5_0080;
        step(0, 1, "prerst_ls");
        ls_v = 0; if_v = 1; if_a = 32'h8000_0000; if_exp = 32'hA5A5_0000;
        step(1, 0, "prerst_if");
        if_v = 0;
        rst_n = 0;
        qa_if.delete(); qa_ls.delete(); qb_if.delete(); qb_ls.delete();
        @(negedge clk);
        chk("midrst_ls_rsp_valid", bus_a.ls_rsp_valid, 0);
        chk("midrst_if_rsp_valid", bus_a.if_rsp_valid, 0);
        @(posedge clk);
        #1 rst_n = 1;
        idle(6);

        chk("end_qa_if_empty", qa_if.size(), 0);
        chk("end_qa_ls_empty", qa_ls.size(), 0);
        chk("end_qb_if_empty", qb_if.size(), 0);
        chk("end_qb_ls_empty", qb_ls.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
